// File: rtl/soc_system_enc_pkg.sv
// Shared types and constants for the encoder PIO scan scheduler.
package soc_system_enc_pkg;

  localparam int unsigned ENC_W = 32;
  localparam logic [1:0]  PIO_DATA_ADDR = 2'd0;

  typedef logic [ENC_W-1:0] enc_word_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    COMMIT
  } scan_state_e;

endpackage

// File: rtl/soc_system_enc_poll_sched_if.sv
// Shared Avalon-MM read path from the scheduler to the encoder PIO slaves.
interface soc_system_enc_poll_sched_if #(
  parameter int NUM_ENC = 4
);

  logic [NUM_ENC-1:0] enc_sel;
  logic [1:0]         enc_address;
  logic               enc_read;
  logic [31:0]        enc_readdata;

  modport master (
    output enc_sel,
    output enc_address,
    output enc_read,
    input  enc_readdata
  );

  modport slave (
    input  enc_sel,
    input  enc_address,
    input  enc_read,
    output enc_readdata
  );

endinterface

// File: rtl/soc_system_enc_tick_gen.sv
// Periodic scan-start tick; the counter idles at 0 while enable is low.
module soc_system_enc_tick_gen #(
  parameter int PERIOD_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;

  logic [CW-1:0] cnt;

  // Tick is registered, so the first one lands PERIOD_CYCLES cycles after enable rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (!enable) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(PERIOD_CYCLES - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/soc_system_enc_poll_sched.sv
// Scans every encoder PIO once per start, then commits an atomic snapshot plus deltas.
import soc_system_enc_pkg::*;

module soc_system_enc_poll_sched #(
  parameter int NUM_ENC       = 4,
  parameter int PERIOD_CYCLES = 50000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       sw_trigger,
  input  logic                       overrun_clr,
  soc_system_enc_poll_sched_if.master enc_bus,
  output logic [NUM_ENC*ENC_W-1:0]   snap_data,
  output logic [NUM_ENC*ENC_W-1:0]   delta,
  output logic                       sample_valid,
  output logic [15:0]                sample_count,
  output logic                       busy,
  output logic                       overrun
);

  localparam int unsigned IDX_W = (NUM_ENC > 1) ? $clog2(NUM_ENC) : 1;

  scan_state_e      state;
  logic [IDX_W-1:0] idx;
  enc_word_t        shadow [NUM_ENC];
  logic             first_done;
  logic             tick;
  logic             start;

  soc_system_enc_tick_gen #(
    .PERIOD_CYCLES (PERIOD_CYCLES)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  assign start               = tick | sw_trigger;
  assign busy                = (state != IDLE);
  assign enc_bus.enc_address = PIO_DATA_ADDR;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      idx              <= '0;
      first_done       <= 1'b0;
      enc_bus.enc_sel  <= '0;
      enc_bus.enc_read <= 1'b0;
      snap_data        <= '0;
      delta            <= '0;
      sample_valid     <= 1'b0;
      sample_count     <= '0;
      overrun          <= 1'b0;
      for (int unsigned i = 0; i < NUM_ENC; i++) shadow[i] <= '0;
    end else begin
      sample_valid <= 1'b0;

      // A new overrun wins over a simultaneous clear.
      if (start && state != IDLE) overrun <= 1'b1;
      else if (overrun_clr)       overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state            <= ISSUE;
            idx              <= '0;
            enc_bus.enc_read <= 1'b1;
            enc_bus.enc_sel  <= NUM_ENC'(1);
          end
        end
        ISSUE: begin
          enc_bus.enc_read <= 1'b0;
          state            <= WAIT;
        end
        WAIT: begin
          shadow[idx] <= enc_bus.enc_readdata;
          if (idx == IDX_W'(NUM_ENC - 1)) begin
            enc_bus.enc_sel <= '0;
            state           <= COMMIT;
          end else begin
            idx              <= idx + 1'b1;
            enc_bus.enc_sel  <= enc_bus.enc_sel << 1;
            enc_bus.enc_read <= 1'b1;
            state            <= ISSUE;
          end
        end
        COMMIT: begin
          for (int unsigned i = 0; i < NUM_ENC; i++) begin
            snap_data[i*ENC_W +: ENC_W] <= shadow[i];
            delta[i*ENC_W +: ENC_W]     <= first_done ?
                                           shadow[i] - snap_data[i*ENC_W +: ENC_W] : '0;
          end
          first_done   <= 1'b1;
          sample_count <= sample_count + 1'b1;
          sample_valid <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_system_enc_poll_sched.sv
// Directed bench for the encoder scan scheduler with a 4-channel PIO responder model.
module tb_soc_system_enc_poll_sched;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic         sw_trigger = 1'b0;
  logic         overrun_clr = 1'b0;
  logic [127:0] snap_data;
  logic [127:0] delta;
  logic         sample_valid;
  logic [15:0]  sample_count;
  logic         busy;
  logic         overrun;

  int n_asserts = 0;
  int n_fails   = 0;

  logic [31:0] pio_val [4];
  logic [31:0] rd_data = '0;
  logic [3:0]  sel_q [$];

  soc_system_enc_poll_sched_if #(.NUM_ENC(4)) bus ();

  soc_system_enc_poll_sched #(
    .NUM_ENC       (4),
    .PERIOD_CYCLES (20)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .sw_trigger   (sw_trigger),
    .overrun_clr  (overrun_clr),
    .enc_bus      (bus.master),
    .snap_data    (snap_data),
    .delta        (delta),
    .sample_valid (sample_valid),
    .sample_count (sample_count),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // PIO slaves: data appears one cycle after the read strobe.
  assign bus.enc_readdata = rd_data;
  always @(posedge clk) begin
    if (bus.enc_read) begin
      sel_q.push_back(bus.enc_sel);
      for (int i = 0; i < 4; i++)
        if (bus.enc_sel[i]) rd_data <= pio_val[i];
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_scan(output int lat);
    sw_trigger = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      sw_trigger = 1'b0;
    end while (!sample_valid && lat < 50);
  endtask

  initial begin
    int lat, n, last, bad, waited;
    logic [15:0] sel_pack;

    for (int i = 0; i < 4; i++) pio_val[i] = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_snap", snap_data, '0);
    chk("reset_outs", {busy, overrun, sample_valid, bus.enc_read, bus.enc_sel, sample_count},
        '0);
    reset = 1'b0;
    @(negedge clk);

    // Scan 1: first scan reports zero deltas
    pio_val[0] = 32'd10; pio_val[1] = 32'd20; pio_val[2] = 32'd30; pio_val[3] = 32'd40;
    sel_q.delete();
    run_scan(lat);
    chk("s1_latency", lat, 10);
    chk("s1_snap", snap_data, {32'd40, 32'd30, 32'd20, 32'd10});
    chk("s1_delta", delta, '0);
    chk("s1_count", sample_count, 16'd1);
    chk("s1_nreads", sel_q.size(), 4);
    sel_pack = {sel_q[3], sel_q[2], sel_q[1], sel_q[0]};
    chk("s1_sel_seq", sel_pack, 16'h8421);
    @(negedge clk);
    chk("s1_valid_pulse", sample_valid, 1'b0);

    // Scan 2: signed deltas including a negative one
    pio_val[0] = 32'd15; pio_val[1] = 32'd18; pio_val[2] = 32'd30; pio_val[3] = 32'h7FFF_FFFF;
    run_scan(lat);
    chk("s2_latency", lat, 10);
    chk("s2_delta", delta, {32'h7FFF_FFD7, 32'd0, 32'hFFFF_FFFE, 32'd5});
    chk("s2_count", sample_count, 16'd2);

    // Periodic scanning: one sample every 20 cycles
    enable = 1'b1;
    n = 0; last = -1; bad = 0;
    for (int c = 0; c < 215; c++) begin
      @(negedge clk);
      if (sample_valid) begin
        if (last >= 0 && c - last != 20) bad++;
        if (n == 0 && c != 29) bad++;
        last = c;
        n++;
      end
    end
    chk("p_nsamples", n, 10);
    chk("p_interval", bad, 0);
    chk("p_overrun", overrun, 1'b0);

    // Drop enable mid-scan: the scan still completes, then nothing more
    waited = 0;
    while (!busy && waited < 30) begin @(negedge clk); waited++; end
    chk("p_busy_seen", busy, 1'b1);
    @(negedge clk);
    enable = 1'b0;
    waited = 0;
    while (!sample_valid && waited < 20) begin @(negedge clk); waited++; end
    chk("p_last_scan_done", sample_valid, 1'b1);
    chk("p_count", sample_count, 16'd13);
    n = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (sample_valid) n++;
    end
    chk("p_no_more_ticks", n, 0);

    // Overrun: trigger during a scan is dropped
    sw_trigger = 1'b1;
    @(negedge clk); sw_trigger = 1'b0;
    @(negedge clk);
    @(negedge clk); sw_trigger = 1'b1;
    @(negedge clk); sw_trigger = 1'b0;
    chk("ov_set", overrun, 1'b1);
    n = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (sample_valid) n++;
    end
    chk("ov_one_sample", n, 1);
    overrun_clr = 1'b1;
    @(negedge clk); overrun_clr = 1'b0;
    chk("ov_clear", overrun, 1'b0);
    sw_trigger = 1'b1;
    @(negedge clk); sw_trigger = 1'b0;
    @(negedge clk); sw_trigger = 1'b1; overrun_clr = 1'b1;
    @(negedge clk); sw_trigger = 1'b0; overrun_clr = 1'b0;
    chk("ov_set_beats_clr", overrun, 1'b1);
    repeat (15) @(negedge clk);

    // Reset in WAIT of channel 2
    sw_trigger = 1'b1;
    @(negedge clk); sw_trigger = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_busy_before", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("rst_snap", snap_data, '0);
    chk("rst_delta", delta, '0);
    chk("rst_outs", {busy, overrun, sample_valid, bus.enc_read, bus.enc_sel, sample_count},
        '0);
    @(negedge clk);
    reset = 1'b0;
    pio_val[0] = 32'd100; pio_val[1] = 32'd200; pio_val[2] = 32'd300; pio_val[3] = 32'd2;
    @(negedge clk);
    run_scan(lat);
    chk("rst_scan_latency", lat, 10);
    chk("rst_scan_delta", delta, '0);
    chk("rst_scan_snap", snap_data, {32'd2, 32'd300, 32'd200, 32'd100});
    chk("rst_scan_count", sample_count, 16'd1);

    // Delta wrap on channel 3 and sample_count wrap
    pio_val[3] = 32'hFFFF_FFFE;
    force dut.sample_count = 16'hFFFF;
    #1;
    release dut.sample_count;
    @(negedge clk);
    run_scan(lat);
    chk("wrap_count", sample_count, 16'h0000);
    chk("wrap_delta", delta, {32'hFFFF_FFFC, 32'd0, 32'd0, 32'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
